// File: rtl/shift_add_multiplier_if.sv
// Handshake bundle for the iterative shift-add multiplier.
// The master side supplies operands and accepts products; the slave side is the multiplier.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 16
) ();
    logic                   start;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output start, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  start, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier.
// One partial product is folded into the accumulator per clock through a 2*WIDTH-bit adder.
// Operands arrive on a valid/ready handshake and the product leaves on a second one.
// All outputs are decoded from registers only; nothing combinational flows from inputs to outputs.
module shift_add_multiplier #(
    parameter int WIDTH      = 16,
    parameter int EARLY_EXIT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    shift_add_multiplier_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0]   mcand_s;
    logic [WIDTH-1:0]     mplier_r;
    logic [WIDTH-1:0]     mplier_s;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   acc_s;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_s;
    logic                 last_iter_s;

    // Shared 2*WIDTH adder; the carry-out is dropped because the exact product always fits.
    function automatic logic [2*WIDTH-1:0] add_2w(
        input logic [2*WIDTH-1:0] x,
        input logic [2*WIDTH-1:0] y
    );
        logic [2*WIDTH:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        return sum[2*WIDTH-1:0];
    endfunction

    // Terminate on the final counted iteration, or early once no multiplier bits remain above bit 0.
    always_comb begin
        last_iter_s = 1'b0;
        if (count_r == CW'(WIDTH - 1)) begin
            last_iter_s = 1'b1;
        end else if ((EARLY_EXIT != 0) && (mplier_r[WIDTH-1:1] == '0)) begin
            last_iter_s = 1'b1;
        end else begin
            last_iter_s = 1'b0;
        end
    end

    // Next-state and datapath update: load in IDLE, one shift-add per RUN cycle, hold in DONE.
    always_comb begin
        state_s  = state_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        acc_s    = acc_r;
        count_s  = count_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    mcand_s  = {{WIDTH{1'b0}}, bus.a};
                    mplier_s = bus.b;
                    acc_s    = '0;
                    count_s  = '0;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                acc_s    = add_2w(acc_r, mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
                mcand_s  = {mcand_r[2*WIDTH-2:0], 1'b0};
                mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
                count_s  = count_r + CW'(1);
                if (last_iter_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers; reset abandons any operation in flight and clears the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            count_r  <= '0;
        end else begin
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            acc_r    <= acc_s;
            count_r  <= count_s;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.busy      = (state_r == RUN);
    assign bus.out_valid = (state_r == DONE);
    assign bus.product   = acc_r;

endmodule
